// File: rtl/flux_pkg.sv
// Shared defaults and tagged-word layout for the multi-flux FIFO feeder.
// The tag occupies the MSBs so the FIFO can steer a word by its top bits alone.
package flux_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_FLUX       = 4;
  localparam int TAG_W          = $clog2(DEF_FLUX);

  typedef struct packed {
    logic [TAG_W-1:0]          tag;
    logic [DEF_DATA_WIDTH-1:0] payload;
  } tagged_word_t;

  function automatic logic [TAG_W-1:0] word_tag(input tagged_word_t w);
    return w.tag;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping; zero latency.
// Purely combinational, no backpressure of its own; pointer state lives in the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      int              j;
      logic [IW-1:0]   jj;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      jj = j[IW-1:0];
      if (grant == '0 && req[jj]) begin
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

// File: rtl/flux_input_arbiter.sv
// Round-robin merge of FLUX producer streams onto one tagged FIFO write port, latency 1.
// in_ready is a one-hot grant gated by per-flux full and by the write still on the port.
module flux_input_arbiter
  import flux_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FLUX       = DEF_FLUX,
  parameter int CNT_WIDTH  = 16,
  localparam int TAG_W     = $clog2(FLUX)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLUX*DATA_WIDTH-1:0]  in_data,
  input  logic [FLUX-1:0]             in_valid,
  output logic [FLUX-1:0]             in_ready,
  output logic [DATA_WIDTH+TAG_W-1:0] din,
  output logic                        write,
  input  logic [FLUX-1:0]             full,
  input  logic                        cnt_clear,
  output logic [FLUX*CNT_WIDTH-1:0]   sent_cnt
);

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] payload;
  } word_t;

  word_t                 din_q;
  logic                  write_q;
  logic [TAG_W-1:0]      ptr_q;
  logic [FLUX-1:0]       busy;
  logic [FLUX-1:0]       eligible;
  logic [FLUX-1:0]       grant;
  logic [TAG_W-1:0]      gidx;
  logic [CNT_WIDTH-1:0]  cnt_q [FLUX];

  // full only reflects our write a cycle late, so mask the flux still on the port
  always_comb begin
    busy = '0;
    if (write_q) busy[din_q.tag] = 1'b1;
  end

  assign eligible = in_valid & ~full & ~busy;

  rr_arbiter #(.N(FLUX), .IW(TAG_W)) u_rr (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gidx)
  );

  assign in_ready = rst ? grant : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q <= 1'b0;
      din_q   <= '0;
      ptr_q   <= '0;
    end else begin
      write_q <= |grant;
      if (|grant) begin
        din_q.tag     <= gidx;
        din_q.payload <= in_data[gidx*DATA_WIDTH +: DATA_WIDTH];
        ptr_q         <= (gidx == TAG_W'(FLUX-1)) ? '0 : gidx + TAG_W'(1);
      end
    end
  end

  // clear wins over a coincident grant, so that word goes uncounted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FLUX; i++) cnt_q[i] <= '0;
    end else if (cnt_clear) begin
      for (int i = 0; i < FLUX; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < FLUX; i++)
        if (grant[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < FLUX; g++) begin : g_cnt
    assign sent_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

  assign write = write_q;
  assign din   = din_q;

endmodule
